// File: rtl/magnetron_pkg.sv
// rtl/magnetron_pkg.sv - shared BCD widths, digit limits and range check for the magnetron timer
package magnetron_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
  localparam int MAX_MINUTES = 99;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit,
                                     input logic [BCD_W-1:0] max);
    return digit <= max;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit that wraps to MAX and borrows from the next digit
module bcd_down_digit
  import magnetron_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == '0) ? MAX : digit - 1'b1;
    end
  end

  assign borrow_out = dec && (digit == '0);

endmodule

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - MM:SS BCD cook timer: keypad load, per-second countdown while the magnetron runs
module cook_timer
  import magnetron_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int PRESCALE_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clearn,
  input  logic             load_en,
  input  logic [BCD_W-1:0] load_min_tens,
  input  logic [BCD_W-1:0] load_min_ones,
  input  logic [BCD_W-1:0] load_sec_tens,
  input  logic [BCD_W-1:0] load_sec_ones,
  input  logic             mag_on,
  output logic             timer_done,
  output logic             load_err,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] presc;
  logic load_valid, load_ok, load_rej, active, tick, done_next;
  logic sec_ones_borrow, sec_tens_borrow, min_ones_borrow, min_tens_borrow_unused;

  assign load_valid = bcd_valid(load_min_tens, DIGIT_MAX) && bcd_valid(load_min_ones, DIGIT_MAX) &&
                      bcd_valid(load_sec_tens, SEC_TENS_MAX) && bcd_valid(load_sec_ones, DIGIT_MAX);
  assign load_ok  = clearn && load_en && !mag_on && load_valid;
  assign load_rej = clearn && load_en && !load_ok;
  assign active   = clearn && !load_en && mag_on && !timer_done;
  assign tick     = active && (presc == PRESC_LAST);

  // timer_done tracks the value the digits will hold after this edge; only 00:01 can tick down to zero
  always_comb begin
    done_next = timer_done;
    if (!clearn) begin
      done_next = 1'b1;
    end else if (load_ok) begin
      done_next = {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} == '0;
    end else if (tick) begin
      done_next = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc      <= '0;
      timer_done <= 1'b1;
      load_err   <= 1'b0;
    end else begin
      timer_done <= done_next;
      load_err   <= load_rej;
      if (!clearn || load_ok || tick) begin
        presc <= '0;
      end else if (active) begin
        presc <= presc + 1'b1;
      end
    end
  end

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .resetn(resetn), .clr(!clearn), .load(load_ok), .load_val(load_sec_ones),
    .dec(tick), .digit(sec_ones), .borrow_out(sec_ones_borrow)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .resetn(resetn), .clr(!clearn), .load(load_ok), .load_val(load_sec_tens),
    .dec(sec_ones_borrow), .digit(sec_tens), .borrow_out(sec_tens_borrow)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(clk), .resetn(resetn), .clr(!clearn), .load(load_ok), .load_val(load_min_ones),
    .dec(sec_tens_borrow), .digit(min_ones), .borrow_out(min_ones_borrow)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(clk), .resetn(resetn), .clr(!clearn), .load(load_ok), .load_val(load_min_tens),
    .dec(min_ones_borrow), .digit(min_tens), .borrow_out(min_tens_borrow_unused)
  );

endmodule
